// File: rtl/demo_scene_renderer_if.sv
// Video bus between the VGA timing generator and the scene renderer.
// The master side drives counters and raw syncs; the slave side returns RGB and realigned syncs.
interface demo_scene_renderer_if;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic       hsync_in;
  logic       vsync_in;
  logic [1:0] r;
  logic [1:0] g;
  logic [1:0] b;
  logic       hsync_out;
  logic       vsync_out;

  modport master (
    output hpos, vpos, display_on, hsync_in, vsync_in,
    input  r, g, b, hsync_out, vsync_out
  );

  modport slave (
    input  hpos, vpos, display_on, hsync_in, vsync_in,
    output r, g, b, hsync_out, vsync_out
  );
endinterface

// File: rtl/demo_scene_renderer.sv
// Two-stage pixel renderer with a frame-locked scene sequencer.
// state      | meaning
// SC_BARS    | eight vertical colour bars from hpos[8:6]
// SC_CHECKER | 32-pixel checkerboard scrolling horizontally with frame_cnt
// SC_XOR     | hpos^vpos pattern offset by frame_cnt
module demo_scene_renderer #(
  parameter int unsigned FRAMES_PER_SCENE = 120
) (
  input  logic                 clk,
  input  logic                 reset,
  demo_scene_renderer_if.slave vid,
  input  logic                 pause,
  input  logic                 next_scene,
  output logic [7:0]           frame_cnt,
  output logic [1:0]           scene
);

  typedef enum logic [1:0] {
    SC_BARS    = 2'd0,
    SC_CHECKER = 2'd1,
    SC_XOR     = 2'd2
  } scene_e;

  localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_SCENE - 1);

  scene_e     scene_q;
  logic [7:0] frame_cnt_q;
  logic [7:0] fis_q;
  logic       pending_q;

  logic       frame_tick;
  logic       advance;
  logic       chk_bit;

  logic [7:0] v_d, v_q;
  logic       den_q;
  scene_e     scene_p_q;
  logic [1:0] r_d, g_d, b_d;
  logic [1:0] r_q, g_q, b_q;
  logic       hs_q, vs_q;

  // Start of vertical blank: scene changes here never tear a visible frame.
  assign frame_tick = (vid.hpos == 10'd0) && (vid.vpos == 10'd480);
  assign advance    = frame_tick &&
                      (pending_q || next_scene || (!pause && fis_q == LAST_FRAME));

  always_ff @(posedge clk) begin
    if (reset) begin
      scene_q     <= SC_BARS;
      frame_cnt_q <= '0;
      fis_q       <= '0;
      pending_q   <= 1'b0;
    end else begin
      if (frame_tick && !pause) frame_cnt_q <= frame_cnt_q + 8'd1;
      if (advance) begin
        fis_q     <= '0;
        pending_q <= 1'b0;
        case (scene_q)
          SC_BARS:    scene_q <= SC_CHECKER;
          SC_CHECKER: scene_q <= SC_XOR;
          default:    scene_q <= SC_BARS;
        endcase
      end else begin
        if (frame_tick && !pause) fis_q <= fis_q + 8'd1;
        if (next_scene) pending_q <= 1'b1;
      end
    end
  end

  // Bit 5 of the scrolled x coordinate only depends on the low six bits of the sum.
  assign chk_bit = 6'(vid.hpos[5:0] + frame_cnt_q[5:0]) >= 6'd32;

  always_comb begin
    v_d = '0;
    case (scene_q)
      SC_BARS:    v_d = {5'b0, vid.hpos[8:6]};
      SC_CHECKER: v_d = {7'b0, chk_bit ^ vid.vpos[5]};
      SC_XOR:     v_d = (vid.hpos[7:0] ^ vid.vpos[7:0]) + frame_cnt_q;
      default:    v_d = '0;
    endcase
  end

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (den_q) begin
      case (scene_p_q)
        SC_BARS: begin
          r_d = {2{v_q[2]}};
          g_d = {2{v_q[1]}};
          b_d = {2{v_q[0]}};
        end
        SC_CHECKER: begin
          r_d = {2{v_q[0]}};
          g_d = {2{v_q[0]}};
          b_d = {2{v_q[0]}};
        end
        SC_XOR: begin
          r_d = v_q[7:6];
          g_d = v_q[5:4];
          b_d = v_q[3:2];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q       <= '0;
      den_q     <= 1'b0;
      scene_p_q <= SC_BARS;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
    end else begin
      v_q       <= v_d;
      den_q     <= vid.display_on;
      scene_p_q <= scene_q;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hs_q      <= vid.hsync_in;
      vs_q      <= vid.vsync_in;
    end
  end

  assign vid.r         = r_q;
  assign vid.g         = g_q;
  assign vid.b         = b_q;
  assign vid.hsync_out = hs_q;
  assign vid.vsync_out = vs_q;
  assign frame_cnt     = frame_cnt_q;
  assign scene         = scene_q;

endmodule

// File: tb/tb_demo_scene_renderer.sv
// Directed bench for demo_scene_renderer: a pixel/scene model checked every cycle,
// plus literal spot checks that pin the model to hand-computed values.
module tb_demo_scene_renderer;
  localparam int FPS = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pause = 1'b0;
  logic       next_scene = 1'b0;
  logic [7:0] frame_cnt;
  logic [1:0] scene;

  demo_scene_renderer_if vid();

  demo_scene_renderer #(.FRAMES_PER_SCENE(FPS)) dut (
    .clk        (clk),
    .reset      (reset),
    .vid        (vid.slave),
    .pause      (pause),
    .next_scene (next_scene),
    .frame_cnt  (frame_cnt),
    .scene      (scene)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Spec-level model: scene index mod 3, frame count mod 256, two-deep pixel delay line.
  int m_scene, m_fc, m_fis;
  bit m_pend, m_adv, model_live = 1'b0;
  int m_r1, m_g1, m_b1, m_r2, m_g2, m_b2, m_hs, m_vs;
  int pr, pg, pb;

  function automatic void render(input int h, input int v, input bit on, input int sc,
                                 input int fc, output int rr, output int gg, output int bb);
    int val;
    rr = 0; gg = 0; bb = 0;
    if (on) begin
      if (sc == 0) begin
        val = (h / 64) % 8;
        rr = (val / 4) % 2 * 3;
        gg = (val / 2) % 2 * 3;
        bb = val % 2 * 3;
      end else if (sc == 1) begin
        val = ((((h + fc) % 1024) / 32) % 2) ^ ((v / 32) % 2);
        rr = val * 3; gg = val * 3; bb = val * 3;
      end else begin
        val = (((h % 256) ^ (v % 256)) + fc) % 256;
        rr = val / 64;
        gg = (val / 16) % 4;
        bb = (val / 4) % 4;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_scene = 0; m_fc = 0; m_fis = 0; m_pend = 0;
      m_r1 = 0; m_g1 = 0; m_b1 = 0; m_r2 = 0; m_g2 = 0; m_b2 = 0;
      m_hs = 1; m_vs = 1;
      model_live = 1'b1;
    end else begin
      render(int'(vid.hpos), int'(vid.vpos), vid.display_on, m_scene, m_fc, pr, pg, pb);
      m_r2 = m_r1; m_g2 = m_g1; m_b2 = m_b1;
      m_r1 = pr;   m_g1 = pg;   m_b1 = pb;
      m_hs = int'(vid.hsync_in);
      m_vs = int'(vid.vsync_in);
      if (vid.hpos == 10'd0 && vid.vpos == 10'd480) begin
        m_adv = m_pend || next_scene || (!pause && m_fis == FPS - 1);
        if (!pause) begin
          m_fc = (m_fc + 1) % 256;
          m_fis = m_fis + 1;
        end
        if (m_adv) begin
          m_scene = (m_scene + 1) % 3;
          m_fis = 0;
          m_pend = 0;
        end
      end else if (next_scene) begin
        m_pend = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("model_r", int'(vid.r), m_r2);
      check("model_g", int'(vid.g), m_g2);
      check("model_b", int'(vid.b), m_b2);
      check("model_hsync", int'(vid.hsync_out), m_hs);
      check("model_vsync", int'(vid.vsync_out), m_vs);
      check("model_frame_cnt", int'(frame_cnt), m_fc);
      check("model_scene", int'(scene), m_scene);
    end
  end

  task automatic drive(input int h, input int v, input bit hs = 1'b1, input bit vs = 1'b1,
                       input bit ns = 1'b0);
    @(posedge clk);
    #1;
    vid.hpos       = 10'(h);
    vid.vpos       = 10'(v);
    vid.display_on = (h < 640) && (v < 480);
    vid.hsync_in   = hs;
    vid.vsync_in   = vs;
    next_scene     = ns;
  endtask

  task automatic probe(input string nm, input int h, input int v,
                       input int er, input int eg, input int eb);
    drive(h, v);
    drive(h + 1, v);
    drive(h + 2, v);
    @(negedge clk);
    check({nm, "_r"}, int'(vid.r), er);
    check({nm, "_g"}, int'(vid.g), eg);
    check({nm, "_b"}, int'(vid.b), eb);
  endtask

  task automatic tick(input bit ns = 1'b0);
    drive(0, 480, 1'b1, 1'b0, ns);
    drive(5, 490, 1'b1, 1'b0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0);
    drive(1, 0);
    reset = 1'b0;
  endtask

  int seq_exp[6] = '{0, 1, 1, 2, 2, 0};
  int low_cnt, first_low, nz_cnt;

  initial begin
    vid.hpos = '0; vid.vpos = '0; vid.display_on = 1'b1;
    vid.hsync_in = 1'b1; vid.vsync_in = 1'b1;

    // Reset with counters running from 0,0.
    for (int i = 0; i < 4; i++) drive(i, 0);
    @(negedge clk);
    check("reset_r", int'(vid.r), 0);
    check("reset_hsync", int'(vid.hsync_out), 1);
    check("reset_vsync", int'(vid.vsync_out), 1);
    reset = 1'b0;

    probe("bars_200_10", 200, 10, 0, 3, 3);

    // Paused manual advance: scene steps, frame_cnt holds.
    pause = 1'b1;
    drive(50, 50, 1'b1, 1'b1, 1'b1);
    drive(51, 50);
    tick();
    check("paused_next_scene", int'(scene), 1);
    check("paused_frame_cnt", int'(frame_cnt), 0);
    probe("checker_fc0", 32, 0, 3, 3, 3);
    drive(60, 60, 1'b1, 1'b1, 1'b1);
    tick();
    check("paused_next_scene2", int'(scene), 2);
    probe("xor_5_3", 5, 3, 0, 0, 1);
    pause = 1'b0;

    // One full line with hsync_in low for cycles 657..752.
    do_reset();
    low_cnt = 0; first_low = -1; nz_cnt = 0;
    for (int c = 0; c <= 801; c++) begin
      drive(c % 800, (c < 800) ? 10 : 11, !(c >= 657 && c <= 752));
      @(negedge clk);
      if (vid.hsync_out == 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = c;
      end
      if (c >= 642 && (vid.r != 0 || vid.g != 0 || vid.b != 0)) nz_cnt++;
    end
    check("hsync_low_len", low_cnt, 96);
    check("hsync_first_low", first_low, 658);
    check("blank_rgb_nonzero", nz_cnt, 0);

    // Auto-advance every FPS frames.
    do_reset();
    @(negedge clk);
    check("seq_start", int'(scene), 0);
    for (int k = 0; k < 6; k++) begin
      drive(100, 100);
      drive(300, 200);
      tick();
      check($sformatf("seq_%0d", k + 1), int'(scene), seq_exp[k]);
    end
    check("seq_frame_cnt", int'(frame_cnt), 6);
    tick();
    check("seq_tick7", int'(scene), 0);
    tick(1'b1);
    check("coincident_single_step", int'(scene), 1);
    tick();
    check("coincident_no_leftover", int'(scene), 1);
    check("coincident_frame_cnt", int'(frame_cnt), 9);

    // Two pulses before one paused tick give a single step.
    pause = 1'b1;
    drive(10, 20, 1'b1, 1'b1, 1'b1);
    drive(11, 20);
    drive(12, 20, 1'b1, 1'b1, 1'b1);
    drive(13, 20);
    tick();
    check("absorbed_pulses", int'(scene), 2);
    check("absorbed_frame_cnt", int'(frame_cnt), 9);
    pause = 1'b0;

    // Reset in the middle of a visible line.
    drive(100, 10, 1'b0);
    drive(101, 10, 1'b0);
    drive(102, 10, 1'b0);
    @(negedge clk);
    check("pre_reset_r", int'(vid.r), 1);
    check("pre_reset_hsync", int'(vid.hsync_out), 0);
    drive(103, 10, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midline_reset_r", int'(vid.r), 0);
    check("midline_reset_g", int'(vid.g), 0);
    check("midline_reset_b", int'(vid.b), 0);
    check("midline_reset_hsync", int'(vid.hsync_out), 1);
    check("midline_reset_scene", int'(scene), 0);
    check("midline_reset_frame_cnt", int'(frame_cnt), 0);
    drive(104, 10);
    reset = 1'b0;

    // frame_cnt wrap over 256 unpaused frames, with a checker probe at 32.
    for (int i = 0; i < 32; i++) tick();
    check("fc32_frame_cnt", int'(frame_cnt), 32);
    check("fc32_scene", int'(scene), 1);
    probe("checker_fc32", 32, 0, 0, 0, 0);
    for (int i = 0; i < 224; i++) tick();
    check("wrap_frame_cnt", int'(frame_cnt), 0);
    check("wrap_scene", int'(scene), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
